// File: rtl/iomem_dma_pkg.sv
// iomem_dma_pkg: register map, CTRL/STATUS bit positions and FSM encoding
// shared by the iomem DMA engine and its register file.
`default_nettype none

package iomem_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_ABORT    = 3;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_GAP_W  = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_GAP_R  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iomem_dma_regs.sv
// iomem_dma_regs: responder-side register file with one-cycle ready pulse,
// readback mux and the start/abort/clear strobes consumed by the DMA FSM.
`default_nettype none

module iomem_dma_regs
  import iomem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic             busy,
  input  logic             done,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             irq_en,
  output logic             start,
  output logic             abort,
  output logic             clear
);

  logic [1:0]  sel;
  logic        wr_en;
  logic        ctrl_wr;
  logic        irq_en_q;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign sel         = iomem_addr[3:2];
  assign unused_addr = ^{iomem_addr[31:4], iomem_addr[1:0]};

  // Writes take effect on the edge that ends the ready cycle.
  assign wr_en   = iomem_valid & iomem_ready & (|iomem_wstrb);
  assign ctrl_wr = wr_en & (sel == REG_CTRL);
  assign start   = ctrl_wr & iomem_wdata[CTRL_START] & ~busy;
  assign abort   = ctrl_wr & iomem_wdata[CTRL_ABORT] & busy;
  assign clear   = ctrl_wr & iomem_wdata[CTRL_CLR_DONE];
  assign irq_en  = ctrl_wr ? iomem_wdata[CTRL_IRQ_EN] : irq_en_q;

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_SRC:  rd_mux = src;
      REG_DST:  rd_mux = dst;
      REG_LEN:  rd_mux[LEN_W-1:0] = len;
      REG_CTRL: begin
        rd_mux[STAT_BUSY]   = busy;
        rd_mux[STAT_DONE]   = done;
        rd_mux[STAT_IRQ_EN] = irq_en_q;
      end
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      irq_en_q    <= 1'b0;
    end else begin
      iomem_ready <= iomem_valid & ~iomem_ready;
      iomem_rdata <= (iomem_valid & ~iomem_ready) ? rd_mux : '0;
      if (wr_en && !busy) begin
        case (sel)
          REG_SRC: src <= {iomem_wdata[31:2], 2'b00};
          REG_DST: dst <= {iomem_wdata[31:2], 2'b00};
          REG_LEN: len <= iomem_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en_q <= iomem_wdata[CTRL_IRQ_EN];
    end
  end

endmodule

`default_nettype wire

// File: rtl/iomem_dma.sv
// iomem_dma: word-copy DMA engine; programmed through an iomem responder port,
// moves data with alternating read/write transactions on an iomem master port.
`default_nettype none

module iomem_dma
  import iomem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        irq_done
);

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic             irq_en;
  logic             start;
  logic             abort;
  logic             clear;
  logic             busy;
  logic             done;
  logic             abort_pending;
  logic             abort_now;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] count;
  logic [31:0]      buffer;

  assign busy      = (state != ST_IDLE);
  assign abort_now = abort | abort_pending;

  iomem_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy),
    .done        (done),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .irq_en      (irq_en),
    .start       (start),
    .abort       (abort),
    .clear       (clear)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      m_valid       <= 1'b0;
      m_wstrb       <= 4'h0;
      m_addr        <= '0;
      m_wdata       <= '0;
      irq_done      <= 1'b0;
      done          <= 1'b0;
      abort_pending <= 1'b0;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      count         <= '0;
      buffer        <= '0;
    end else begin
      irq_done <= 1'b0;
      // Later assignments (start, completion) override clear-done.
      if (clear) done <= 1'b0;
      case (state)
        ST_IDLE: begin
          abort_pending <= 1'b0;
          if (start) begin
            if (len == '0) begin
              done     <= 1'b1;
              irq_done <= irq_en;
            end else begin
              src_ptr <= src;
              dst_ptr <= dst;
              count   <= len;
              done    <= 1'b0;
              state   <= ST_GAP_R;
            end
          end
        end
        ST_GAP_R: begin
          if (abort_now) begin
            state <= ST_IDLE;
          end else begin
            m_valid <= 1'b1;
            m_wstrb <= 4'h0;
            m_addr  <= src_ptr;
            state   <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (abort) abort_pending <= 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            buffer  <= m_rdata;
            src_ptr <= src_ptr + 32'd4;
            state   <= abort_now ? ST_IDLE : ST_GAP_W;
          end
        end
        ST_GAP_W: begin
          if (abort_now) begin
            state <= ST_IDLE;
          end else begin
            m_valid <= 1'b1;
            m_wstrb <= 4'hF;
            m_addr  <= dst_ptr;
            m_wdata <= buffer;
            state   <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (abort) abort_pending <= 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            dst_ptr <= dst_ptr + 32'd4;
            count   <= count - LEN_W'(1);
            if (abort_now) begin
              state <= ST_IDLE;
            end else if (count == LEN_W'(1)) begin
              state    <= ST_IDLE;
              done     <= 1'b1;
              irq_done <= irq_en;
            end else begin
              state <= ST_GAP_R;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
